// File: rtl/wb_stage_pkg.sv
// Shared encodings for the write-back stage: write-address select, write-data
// select and the load opcodes that need byte/half extension.
package wb_stage_pkg;

  localparam logic [1:0] WADRS_RD = 2'd0;
  localparam logic [1:0] WADRS_RT = 2'd1;
  localparam logic [1:0] WADRS_31 = 2'd2;

  localparam logic [2:0] WDATA_ALURES = 3'd0;
  localparam logic [2:0] WDATA_MEMRES = 3'd1;
  localparam logic [2:0] WDATA_PC     = 3'd2;
  localparam logic [2:0] WDATA_CP0    = 3'd3;
  localparam logic [2:0] WDATA_HI     = 3'd4;
  localparam logic [2:0] WDATA_LO     = 3'd5;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

endpackage

// File: rtl/wb_stage_if.sv
// Bundle between the M stage / W-stage decoder (master) and the W stage (slave).
// No valid/ready handshake: valid_m is captured whenever stall_w and flush_w are
// both low, flush_w wins over stall_w, and RegWE/WAdrs/WDataSrc describe instr_w.
interface wb_stage_if;
  logic        stall_w;
  logic        flush_w;
  logic        valid_m;
  logic [31:0] instr_m;
  logic [31:0] pc_m;
  logic [31:0] alures_m;
  logic [31:0] memrdata_m;
  logic [31:0] cp0_m;
  logic [31:0] hi_m;
  logic [31:0] lo_m;
  logic [31:0] instr_w;
  logic        RegWE;
  logic [1:0]  WAdrs;
  logic [2:0]  WDataSrc;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        valid_w;

  modport master (
    output stall_w, flush_w, valid_m, instr_m, pc_m, alures_m, memrdata_m,
           cp0_m, hi_m, lo_m, RegWE, WAdrs, WDataSrc,
    input  instr_w, rf_we, rf_waddr, rf_wdata, valid_w
  );

  modport slave (
    input  stall_w, flush_w, valid_m, instr_m, pc_m, alures_m, memrdata_m,
           cp0_m, hi_m, lo_m, RegWE, WAdrs, WDataSrc,
    output instr_w, rf_we, rf_waddr, rf_wdata, valid_w
  );
endinterface

// File: rtl/wb_stage_load_ext.sv
// Little-endian load extraction: picks the byte/half lane from addr and
// sign- or zero-extends it according to the load opcode.
module load_ext
  import wb_stage_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    // Halfword lane depends only on addr[1]; misaligned addr[0] is ignored.
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    ext_data = rdata;
    case (opcode)
      OP_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ext_data = {24'd0, byte_sel};
      OP_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ext_data = {16'd0, half_sel};
      OP_LW:   ext_data = rdata;
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back pipeline stage: M->W register plus register-file address/data
// selection, combinational from the W registers.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  wb_stage_if.slave  bus
);

  logic        valid_r;
  logic [31:0] instr_r;
  logic [31:0] pc_w;
  logic [31:0] alures_w;
  logic [31:0] memrdata_w;
  logic [31:0] cp0_w;
  logic [31:0] hi_w;
  logic [31:0] lo_w;
  logic [31:0] load_data;
  logic [31:0] pc_plus8;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  // A flush only needs to kill valid and instr; the data registers are don't-care.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r    <= 1'b0;
      instr_r    <= 32'd0;
      pc_w       <= 32'd0;
      alures_w   <= 32'd0;
      memrdata_w <= 32'd0;
      cp0_w      <= 32'd0;
      hi_w       <= 32'd0;
      lo_w       <= 32'd0;
    end else if (bus.flush_w) begin
      valid_r    <= 1'b0;
      instr_r    <= 32'd0;
    end else if (!bus.stall_w) begin
      valid_r    <= bus.valid_m;
      instr_r    <= bus.instr_m;
      pc_w       <= bus.pc_m;
      alures_w   <= bus.alures_m;
      memrdata_w <= bus.memrdata_m;
      cp0_w      <= bus.cp0_m;
      hi_w       <= bus.hi_m;
      lo_w       <= bus.lo_m;
    end
  end

  load_ext u_load_ext (
    .opcode   (instr_r[31:26]),
    .addr     (alures_w[1:0]),
    .rdata    (memrdata_w),
    .ext_data (load_data)
  );

  assign pc_plus8 = pc_w + 32'd8;

  always_comb begin
    waddr = 5'd0;
    case (bus.WAdrs)
      WADRS_RD: waddr = instr_r[15:11];
      WADRS_RT: waddr = instr_r[20:16];
      WADRS_31: waddr = 5'd31;
      default:  waddr = 5'd0;
    endcase
  end

  always_comb begin
    wdata = alures_w;
    case (bus.WDataSrc)
      WDATA_ALURES: wdata = alures_w;
      WDATA_MEMRES: wdata = load_data;
      WDATA_PC:     wdata = pc_plus8;
      WDATA_CP0:    wdata = cp0_w;
      WDATA_HI:     wdata = hi_w;
      WDATA_LO:     wdata = lo_w;
      default:      wdata = alures_w;
    endcase
  end

  assign bus.instr_w  = instr_r;
  assign bus.valid_w  = valid_r;
  assign bus.rf_waddr = waddr;
  assign bus.rf_wdata = wdata;
  assign bus.rf_we    = bus.RegWE && valid_r && (waddr != 5'd0);

endmodule
